// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator.
// Walks a pixel raster (h_cnt across a line, v_cnt down the frame) and emits
// registered sync, active-video, coordinate and line/frame strobe signals.
// Every output is a decode of the counter values before the increment, so the
// outputs trail the counters by one enabled cycle. The strobes are one clk wide
// even when en is pulsed at a fraction of the clock rate.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Decode boundaries, pre-sized to the counter width.
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ACT  = SYNC_POL;
  localparam logic SYNC_IDLE = ~SYNC_POL;

  logic [CNT_W-1:0] h_cnt_reg, h_cnt_next;
  logic [CNT_W-1:0] v_cnt_reg, v_cnt_next;

  logic             hsync_reg, hsync_next;
  logic             vsync_reg, vsync_next;
  logic             video_on_reg, video_on_next;
  logic [CNT_W-1:0] pixel_x_reg, pixel_x_next;
  logic [CNT_W-1:0] pixel_y_reg, pixel_y_next;
  logic             line_start_reg, line_start_next;
  logic             frame_start_reg, frame_start_next;

  // Raster advance: h wraps at end of line and carries into v, v wraps at end of frame.
  always_comb begin
    h_cnt_next = h_cnt_reg + 1'b1;
    v_cnt_next = v_cnt_reg;
    if (h_cnt_reg == H_LAST) begin
      h_cnt_next = '0;
      if (v_cnt_reg == V_LAST) begin
        v_cnt_next = '0;
      end else begin
        v_cnt_next = v_cnt_reg + 1'b1;
      end
    end
  end

  // Output decode of the current (pre-increment) raster position.
  always_comb begin
    video_on_next    = (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
    hsync_next       = ((h_cnt_reg >= H_SYNC_BEG) && (h_cnt_reg < H_SYNC_END)) ? SYNC_ACT : SYNC_IDLE;
    vsync_next       = ((v_cnt_reg >= V_SYNC_BEG) && (v_cnt_reg < V_SYNC_END)) ? SYNC_ACT : SYNC_IDLE;
    pixel_x_next     = video_on_next ? h_cnt_reg : '0;
    pixel_y_next     = video_on_next ? v_cnt_reg : '0;
    line_start_next  = (h_cnt_reg == '0);
    frame_start_next = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  end

  // Raster counters, advanced only on pixel-enable edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (en) begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  // Registered outputs: levels hold while en is low, strobes drop after one clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_reg       <= SYNC_IDLE;
      vsync_reg       <= SYNC_IDLE;
      video_on_reg    <= 1'b0;
      pixel_x_reg     <= '0;
      pixel_y_reg     <= '0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else if (en) begin
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      video_on_reg    <= video_on_next;
      pixel_x_reg     <= pixel_x_next;
      pixel_y_reg     <= pixel_y_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
    end else begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end
  end

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign video_on    = video_on_reg;
  assign pixel_x     = pixel_x_reg;
  assign pixel_y     = pixel_y_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized-enable bench for vga_sync_gen.
// Three instances share clk/reset/en: default 640x480 timing, and a tiny
// 15x10 raster with each sync polarity so frame wraps happen often.
// The reference model maps the count of enabled edges since reset straight
// to a raster position with division/modulo and derives every output from it.
module tb_vga_sync_gen;

  // Tiny raster used by instances 1 and 2.
  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVA = 6, SVF = 1, SVS = 2, SVB = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;

  logic       hs0, vs0, von0, ls0, fs0;
  logic [9:0] px0, py0;
  logic       hs1, vs1, von1, ls1, fs1;
  logic [9:0] px1, py1;
  logic       hs2, vs2, von2, ls2, fs2;
  logic [9:0] px2, py2;

  int n_checks = 0;
  int n_pass   = 0;
  int n_edges  = 0;   // enabled edges since last reset
  bit last_en  = 1'b0;
  int cyc      = 0;
  int last_ls  = -1;
  bit spacing_on = 1'b0;

  always #5 clk = ~clk;

  vga_sync_gen u_dut0 (
    .clk(clk), .reset(reset), .en(en),
    .hsync(hs0), .vsync(vs0), .video_on(von0),
    .pixel_x(px0), .pixel_y(py0),
    .line_start(ls0), .frame_start(fs0)
  );

  vga_sync_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_POL(1'b0), .CNT_W(10)
  ) u_dut1 (
    .clk(clk), .reset(reset), .en(en),
    .hsync(hs1), .vsync(vs1), .video_on(von1),
    .pixel_x(px1), .pixel_y(py1),
    .line_start(ls1), .frame_start(fs1)
  );

  vga_sync_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_POL(1'b1), .CNT_W(10)
  ) u_dut2 (
    .clk(clk), .reset(reset), .en(en),
    .hsync(hs2), .vsync(vs2), .video_on(von2),
    .pixel_x(px2), .pixel_y(py2),
    .line_start(ls2), .frame_start(fs2)
  );

  // Expected {hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start}
  // after n enabled edges since reset; strobe_edge says whether the last edge was enabled.
  function automatic logic [24:0] model(input int ha, input int hf, input int hsw, input int hb,
                                        input int va, input int vf, input int vsw, input int vb,
                                        input bit pol, input int n, input bit strobe_edge);
    int ht, vt, p, h, v;
    logic o_hs, o_vs, o_von, o_ls, o_fs;
    int o_px, o_py;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (n == 0) return {~pol, ~pol, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
    p = (n - 1) % (ht * vt);
    h = p % ht;
    v = p / ht;
    o_von = (h < ha) && (v < va);
    o_hs  = (h >= ha + hf && h < ha + hf + hsw) ? pol : ~pol;
    o_vs  = (v >= va + vf && v < va + vf + vsw) ? pol : ~pol;
    o_px  = o_von ? h : 0;
    o_py  = o_von ? v : 0;
    o_ls  = strobe_edge && (h == 0);
    o_fs  = strobe_edge && (h == 0) && (v == 0);
    return {o_hs, o_vs, o_von, 10'(o_px), 10'(o_py), o_ls, o_fs};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (edges=%0d, t=%0t)", tag, obs, exp, n_edges, $time);
    end
  endtask

  task automatic check_all();
    bit se;
    se = last_en && !reset;
    check("dut0_default", {7'd0, hs0, vs0, von0, px0, py0, ls0, fs0},
          {7'd0, model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, n_edges, se)});
    check("dut1_small_pol0", {7'd0, hs1, vs1, von1, px1, py1, ls1, fs1},
          {7'd0, model(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b0, n_edges, se)});
    check("dut2_small_pol1", {7'd0, hs2, vs2, von2, px2, py2, ls2, fs2},
          {7'd0, model(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1, n_edges, se)});
  endtask

  // One clock: drive reset/en at the falling edge, advance the model at the
  // rising edge, compare 1 time unit later.
  task automatic step(input bit e, input bit r);
    @(negedge clk);
    reset = r;
    en    = e;
    @(posedge clk);
    cyc++;
    if (r) n_edges = 0;
    else if (e) n_edges++;
    last_en = e;
    #1;
    check_all();
    if (spacing_on && ls0) begin
      if (last_ls >= 0) check("line_start_spacing", 32'(cyc - last_ls), 32'd800);
      last_ls = cyc;
    end
  endtask

  initial begin
    // Reset asserted asynchronously before any clock edge.
    #3 reset = 1'b1;
    #1;
    n_edges = 0;
    last_en = 1'b0;
    check_all();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    $display("txn reset_hold: cycles=3 checks=%0d passed=%0d", n_checks, n_pass);

    // Free-running pixel clock: two default lines, many small-raster frames.
    spacing_on = 1'b1;
    last_ls = -1;
    for (int i = 0; i < 1700; i++) step(1'b1, 1'b0);
    spacing_on = 1'b0;
    $display("txn full_rate: cycles=1700 checks=%0d passed=%0d", n_checks, n_pass);

    // Random enable pattern.
    for (int i = 0; i < 600; i++) step(1'($urandom_range(0, 1)), 1'b0);
    $display("txn random_en: cycles=600 checks=%0d passed=%0d", n_checks, n_pass);

    // Mid-frame asynchronous reset, checked between clock edges.
    #2 reset = 1'b1;
    #1;
    n_edges = 0;
    last_en = 1'b0;
    check_all();
    for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0);
    $display("txn midframe_reset: cycles=203 checks=%0d passed=%0d", n_checks, n_pass);

    // Enable one clock in four, as when clocked from a 100 MHz system clock.
    for (int i = 0; i < 400; i++) step((i % 4) == 3, 1'b0);
    $display("txn en_quarter: cycles=400 checks=%0d passed=%0d", n_checks, n_pass);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
